// File: rtl/mpwd_pkg.sv
// Shared types and helpers for the multi-channel pulse width detector.
// Pulse classes are shared by the channel logic and the testbench.
package mpwd_pkg;

    typedef enum logic [1:0] {
        PW_NONE,
        PW_SHORT,
        PW_OK,
        PW_LONG
    } pw_class_t;

    // Enough bits to hold MAX_W+1, the saturated "too long" marker.
    function automatic int unsigned cnt_width(input int unsigned max_w);
        return $clog2(max_w + 2);
    endfunction

endpackage

// File: rtl/mpwd_channel.sv
// One channel of the pulse width detector: high-run counter, edge/pulse classification,
// width register and, with MPWD_LOW_PULSE_EN defined, a low-run counter for low pulses.
module mpwd_channel
    import mpwd_pkg::*;
#(
    parameter int unsigned MIN_W = 1,
    parameter int unsigned MAX_W = 1,
    parameter int unsigned CW    = cnt_width(MAX_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    output logic          rise,
    output logic          fall,
    output logic          pulse_ok,
    output logic          too_short,
    output logic          too_long,
    output logic          width_vld,
    output logic [CW-1:0] width,
    output logic          low_ok
);

    localparam logic [CW-1:0] SAT = CW'(MAX_W + 1);
    localparam logic [CW-1:0] LO  = CW'(MIN_W);
    localparam logic [CW-1:0] HI  = CW'(MAX_W);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] width_q;
    logic          width_vld_q;
    pw_class_t     cls;

    always_comb begin
        cnt_d = '0;
        if (a) begin
            cnt_d = (cnt_q == SAT) ? SAT : cnt_q + CW'(1);
        end
    end

    // A non-zero count doubles as the previous-cycle level of the input.
    assign rise = a & (cnt_q == '0);
    assign fall = ~a & (cnt_q != '0);

    always_comb begin
        cls = PW_NONE;
        if (fall) begin
            if (cnt_q < LO) begin
                cls = PW_SHORT;
            end else if (cnt_q > HI) begin
                cls = PW_LONG;
            end else begin
                cls = PW_OK;
            end
        end
    end

    assign pulse_ok  = (cls == PW_OK);
    assign too_short = (cls == PW_SHORT);
    assign too_long  = (cls == PW_LONG);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            width_q     <= '0;
            width_vld_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            width_vld_q <= fall;
            if (fall) begin
                width_q <= cnt_q;
            end
        end
    end

    assign width     = width_q;
    assign width_vld = width_vld_q;

`ifdef MPWD_LOW_PULSE_EN
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic          seen_high_q;

    always_comb begin
        low_cnt_d = '0;
        if (!a) begin
            low_cnt_d = (low_cnt_q == SAT) ? SAT : low_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt_q   <= '0;
            seen_high_q <= 1'b0;
        end else begin
            low_cnt_q   <= low_cnt_d;
            seen_high_q <= seen_high_q | a;
        end
    end

    // The seen-high guard keeps the low level held since reset from looking like a pulse.
    assign low_ok = a & seen_high_q & (low_cnt_q >= LO) & (low_cnt_q <= HI);
`else
    assign low_ok = 1'b0;
`endif

endmodule

// File: rtl/multi_pulse_width_detector.sv
// N-channel rising/falling edge and high-pulse width detector (MIN_W..MAX_W cycles).
// Define MPWD_LOW_PULSE_EN to add per-channel low-pulse detection on low_ok.
module multi_pulse_width_detector
    import mpwd_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned MIN_W = 1,
    parameter int unsigned MAX_W = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CH-1:0]                    a,
    output logic [N_CH-1:0]                    rise,
    output logic [N_CH-1:0]                    fall,
    output logic [N_CH-1:0]                    pulse_ok,
    output logic [N_CH-1:0]                    too_short,
    output logic [N_CH-1:0]                    too_long,
    output logic [N_CH-1:0]                    width_vld,
    output logic [N_CH*cnt_width(MAX_W)-1:0]   width,
    output logic [N_CH-1:0]                    low_ok
);

    localparam int unsigned CW = cnt_width(MAX_W);

    if (N_CH < 1) begin : g_bad_nch
        $error("multi_pulse_width_detector: N_CH must be at least 1");
    end
    if (MIN_W < 1) begin : g_bad_min
        $error("multi_pulse_width_detector: MIN_W must be at least 1");
    end
    if (MAX_W < MIN_W) begin : g_bad_max
        $error("multi_pulse_width_detector: MAX_W must not be below MIN_W");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mpwd_channel #(
            .MIN_W (MIN_W),
            .MAX_W (MAX_W),
            .CW    (CW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .a         (a[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .pulse_ok  (pulse_ok[i]),
            .too_short (too_short[i]),
            .too_long  (too_long[i]),
            .width_vld (width_vld[i]),
            .width     (width[i*CW +: CW]),
            .low_ok    (low_ok[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Directed self-checking bench: default 1..1 detector, a 2..4 detector, and (with
// MPWD_LOW_PULSE_EN) a 2..2 detector exercising low-pulse detection.
module tb_multi_pulse_width_detector;
    import mpwd_pkg::*;

    localparam int unsigned CWA = cnt_width(1);
    localparam int unsigned CWB = cnt_width(4);

    logic clk = 1'b0;
    logic rst;
    logic [3:0] a_a, a_b;

    logic [3:0] rise_a, fall_a, ok_a, short_a, long_a, vld_a, low_a;
    logic [4*CWA-1:0] width_a;
    logic [3:0] rise_b, fall_b, ok_b, short_b, long_b, vld_b, low_b;
    logic [4*CWB-1:0] width_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_pulse_width_detector #(.N_CH(4), .MIN_W(1), .MAX_W(1)) dut_a (
        .clk(clk), .rst(rst), .a(a_a), .rise(rise_a), .fall(fall_a), .pulse_ok(ok_a),
        .too_short(short_a), .too_long(long_a), .width_vld(vld_a), .width(width_a),
        .low_ok(low_a)
    );

    multi_pulse_width_detector #(.N_CH(4), .MIN_W(2), .MAX_W(4)) dut_b (
        .clk(clk), .rst(rst), .a(a_b), .rise(rise_b), .fall(fall_b), .pulse_ok(ok_b),
        .too_short(short_b), .too_long(long_b), .width_vld(vld_b), .width(width_b),
        .low_ok(low_b)
    );

`ifdef MPWD_LOW_PULSE_EN
    localparam int unsigned CWC = cnt_width(2);
    logic [3:0] a_c;
    logic [3:0] rise_c, fall_c, ok_c, short_c, long_c, vld_c, low_c;
    logic [4*CWC-1:0] width_c;

    multi_pulse_width_detector #(.N_CH(4), .MIN_W(2), .MAX_W(2)) dut_c (
        .clk(clk), .rst(rst), .a(a_c), .rise(rise_c), .fall(fall_c), .pulse_ok(ok_c),
        .too_short(short_c), .too_long(long_c), .width_vld(vld_c), .width(width_c),
        .low_ok(low_c)
    );
    localparam logic [3:0] LOW_A_EXP = 4'hF;
`else
    localparam logic [3:0] LOW_A_EXP = 4'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to the next cycle window; inputs set afterwards apply to that window.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_a = '0;
        a_b = '0;
`ifdef MPWD_LOW_PULSE_EN
        a_c = '0;
`endif
        next();
        next();
        #1;
        chk("rst_vld_a", vld_a, 0);
        chk("rst_width_a", width_a, 0);
        chk("rst_vld_b", vld_b, 0);
        chk("rst_width_b", width_b, 0);
        chk("rst_flags_a", {rise_a, fall_a, ok_a, short_a, long_a, low_a}, 0);
        chk("rst_flags_b", {rise_b, fall_b, ok_b, short_b, long_b, low_b}, 0);
        rst = 1'b0;

        // Default detector: 0,1,0 on channel 0.
        next();
        next();
        a_a = 4'b0001;
        #1;
        chk("a_rise", rise_a, 4'b0001);
        chk("a_rise_nofall", fall_a, 4'b0000);
        next();
        a_a = 4'b0000;
        #1;
        chk("a_fall", fall_a, 4'b0001);
        chk("a_ok", ok_a, 4'b0001);
        chk("a_short_const0", short_a, 4'b0000);
        next();
        #1;
        chk("a_vld", vld_a, 4'b0001);
        chk("a_width", width_a, 8'h01);
        chk("a_quiet", {rise_a, fall_a, ok_a}, 0);

        // 2..4 detector, channel 1: widths 1, 3, 4.
        a_b = 4'b0010;
        next();
        a_b = 4'b0000;
        #1;
        chk("b_short_fall", fall_b, 4'b0010);
        chk("b_short", short_b, 4'b0010);
        chk("b_short_nook", ok_b, 4'b0000);
        next();
        #1;
        chk("b_w1_vld", vld_b, 4'b0010);
        chk("b_w1", width_b[CWB*1 +: CWB], 1);

        a_b = 4'b0010;
        repeat (3) next();
        a_b = 4'b0000;
        #1;
        chk("b_w3_ok", ok_b, 4'b0010);
        chk("b_w3_flags", {short_b, long_b}, 0);
        next();
        #1;
        chk("b_w3", width_b[CWB*1 +: CWB], 3);

        a_b = 4'b0010;
        repeat (4) next();
        a_b = 4'b0000;
        #1;
        chk("b_w4_ok", ok_b, 4'b0010);
        next();
        #1;
        chk("b_w4", width_b[CWB*1 +: CWB], 4);

        // Channel 2 held 9 cycles saturates at MAX_W+1.
        a_b = 4'b0100;
        repeat (9) next();
        a_b = 4'b0000;
        #1;
        chk("b_long", long_b, 4'b0100);
        chk("b_long_nook", ok_b, 4'b0000);
        next();
        #1;
        chk("b_long_vld", vld_b, 4'b0100);
        chk("b_w_sat", width_b[CWB*2 +: CWB], 5);

        // Reset in the second cycle of a pulse on channel 3.
        a_b = 4'b1000;
        #1;
        chk("b_rst_rise0", rise_b, 4'b1000);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        #1;
        chk("b_rst_rerise", rise_b, 4'b1000);
        chk("b_rst_nofall", fall_b, 4'b0000);
        chk("b_rst_novld", vld_b, 4'b0000);
        chk("b_rst_width", width_b, 0);
        next();
        a_b = 4'b0000;
        #1;
        chk("b_rst_restart_fall", fall_b, 4'b1000);
        chk("b_rst_restart_short", short_b, 4'b1000);
        chk("b_rst_restart_nook", ok_b, 4'b0000);
        next();

        // All default channels together, then back-to-back.
        a_a = 4'hF;
        next();
        a_a = 4'h0;
        #1;
        chk("a_all_fall", fall_a, 4'hF);
        chk("a_all_ok", ok_a, 4'hF);
        next();
        a_a = 4'hF;
        #1;
        chk("a_all_vld", vld_a, 4'hF);
        chk("a_all_width", width_a, 8'h55);
        chk("a_b2b_rise", rise_a, 4'hF);
        chk("a_low_ok", low_a, {28'h0, LOW_A_EXP});
        next();
        a_a = 4'h0;
        #1;
        chk("a_b2b_fall", fall_a, 4'hF);
        next();

`ifdef MPWD_LOW_PULSE_EN
        // 2..2 detector: low run of 2 straight after reset is ignored, later one is seen.
        rst = 1'b1;
        next();
        rst = 1'b0;
        next();
        next();
        a_c = 4'b0001;
        #1;
        chk("c_low_noguard", low_c, 4'b0000);
        next();
        a_c = 4'b0000;
        next();
        next();
        a_c = 4'b0001;
        #1;
        chk("c_low_ok", low_c, 4'b0001);
        next();
        a_c = 4'b0000;
        next();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
